bus_master_arbiter: RTL and testbench

- Shares the 20-bit memory/IO bus between NREQ DMA-style requesters and the CPU.
- Obtains the bus from the CPU with a HOLD/HLDA handshake, then selects one requester.
- Runs T1/T2/T3/T4 bus cycles for the selected requester: ALE, active-low RD/WR, IOM, Address.
- Sits upstream of the chip-select/OE/WD decode, which consumes these bus signals unchanged.

---
 rtl/bus_master_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_bus_master_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bus_master_arbiter.sv
// bus_master_arbiter: borrows the 20-bit bus from the CPU through HOLD/HLDA,
// selects one of NREQ requesters and runs T1/T2/[TW]/T3/T4 cycles on its behalf.
// Optional feature macro: ARB_FIXED_PRIO_EN (lowest index wins, no burst limit).
// Without the macro: round-robin selection with a MAX_BURST fairness limit.
module bus_master_arbiter #(
  parameter int NREQ        = 2,
  parameter int WAIT_STATES = 1,
  parameter int MAX_BURST   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_wr,
  input  logic [NREQ-1:0]      req_iom,
  input  logic [20*NREQ-1:0]   req_addr,
  input  logic                 HLDA,
  input  logic                 rdy,
  output logic                 HOLD,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [19:0]          Address,
  output logic                 IOM,
  output logic                 ALE,
  output logic                 RD,
  output logic                 WR
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_HOLDW, S_ARB, S_T1, S_T2, S_TW, S_T3, S_T4, S_REL
  } state_t;

  state_t          state_q;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   win_q;
  logic [3:0]      burst_q;
  logic [2:0]      wcnt_q;
  logic            wr_q;
  logic            lost_q;   // HLDA fell while we owned the bus

  logic [PW-1:0]   win_d;
  logic            found_d;
  logic [NREQ-1:0] win_oh;
  logic [NREQ-1:0] win_d_oh;
  logic            others;
  logic            win_req;
  logic [3:0]      burst_inc;
  logic            keep_bus;

  // Winner selection; iterate from lowest priority up so the last hit wins
  always_comb begin
    win_d   = ptr_q;
    found_d = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_d   = PW'(i);
        found_d = 1'b1;
      end
    end
`else
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(ptr_q) + k) % NREQ]) begin
        win_d   = PW'((int'(ptr_q) + k) % NREQ);
        found_d = 1'b1;
      end
    end
`endif
  end

  assign win_oh    = NREQ'(1) << win_q;
  assign win_d_oh  = NREQ'(1) << win_d;
  assign others    = |(req & ~win_oh);
  assign win_req   = |(req & win_oh);
  assign burst_inc = burst_q + 4'd1;

  // burst_q already counts the transfer that just finished when in T4
`ifdef ARB_FIXED_PRIO_EN
  assign keep_bus = win_req;
`else
  assign keep_bus = win_req && (!others || (int'(burst_q) < MAX_BURST));
`endif

  // Bus FSM with every output registered alongside the state
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      HOLD    <= 1'b0;
      gnt     <= '0;
      done    <= '0;
      ALE     <= 1'b0;
      RD      <= 1'b1;
      WR      <= 1'b1;
      Address <= '0;
      IOM     <= 1'b0;
      ptr_q   <= PW'(NREQ - 1);
      win_q   <= '0;
      burst_q <= '0;
      wcnt_q  <= '0;
      wr_q    <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      done <= '0;
      if (state_q inside {S_ARB, S_T1, S_T2, S_TW, S_T3, S_T4} && !HLDA)
        lost_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          lost_q <= 1'b0;
          if (|req) begin
            HOLD    <= 1'b1;
            state_q <= S_HOLDW;
          end
        end
        S_HOLDW: if (HLDA) state_q <= S_ARB;
        S_ARB: begin
          if (!found_d || !HLDA || lost_q) begin
            HOLD    <= 1'b0;
            state_q <= S_REL;
          end else begin
            win_q   <= win_d;
            ptr_q   <= win_d;
            burst_q <= '0;
            wr_q    <= req_wr[win_d];
            IOM     <= req_iom[win_d];
            Address <= req_addr[20*int'(win_d) +: 20];
            gnt     <= win_d_oh;
            ALE     <= 1'b1;
            state_q <= S_T1;
          end
        end
        S_T1: begin
          ALE     <= 1'b0;
          RD      <= wr_q;
          WR      <= !wr_q;
          wcnt_q  <= 3'(WAIT_STATES);
          state_q <= S_T2;
        end
        S_T2: state_q <= (WAIT_STATES > 0) ? S_TW : S_T3;
        S_TW: begin
          wcnt_q <= wcnt_q - 3'd1;
          if (wcnt_q <= 3'd1) state_q <= S_T3;
        end
        S_T3: begin
          if (rdy) begin
            RD      <= 1'b1;
            WR      <= 1'b1;
            done    <= win_oh;
            burst_q <= burst_inc;
            state_q <= S_T4;
          end
        end
        S_T4: begin
          if (lost_q || !HLDA) begin
            gnt     <= '0;
            HOLD    <= 1'b0;
            state_q <= S_REL;
          end else if (keep_bus) begin
            if (!others) burst_q <= '0;
            wr_q    <= req_wr[win_q];
            IOM     <= req_iom[win_q];
            Address <= req_addr[20*int'(win_q) +: 20];
            ALE     <= 1'b1;
            state_q <= S_T1;
          end else if (others) begin
            gnt     <= '0;
            state_q <= S_ARB;
          end else begin
            gnt     <= '0;
            HOLD    <= 1'b0;
            state_q <= S_REL;
          end
        end
        S_REL: begin
          lost_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Directed bench for bus_master_arbiter: reset, read/write cycles, rdy stalls,
// burst fairness and HLDA loss. Inputs change and outputs are sampled at negedge.
module tb_bus_master_arbiter;
  localparam int NR = 2;
  localparam int WS = 1;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NR-1:0]   req = '0;
  logic [NR-1:0]   req_wr = '0;
  logic [NR-1:0]   req_iom = '0;
  logic [20*NR-1:0] req_addr = '0;
  logic            HLDA = 1'b0;
  logic            rdy = 1'b1;
  logic            HOLD;
  logic [NR-1:0]   gnt;
  logic [NR-1:0]   done;
  logic [19:0]     Address;
  logic            IOM, ALE, RD, WR;

  int n_cmp = 0;
  int n_bad = 0;

  bus_master_arbiter #(.NREQ(NR), .WAIT_STATES(WS), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_iom(req_iom),
    .req_addr(req_addr), .HLDA(HLDA), .rdy(rdy), .HOLD(HOLD), .gnt(gnt),
    .done(done), .Address(Address), .IOM(IOM), .ALE(ALE), .RD(RD), .WR(WR)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  // CPU model: grant HLDA two cycles after HOLD is seen
  task automatic start_hold;
    int t = 0;
    while (!HOLD && t < 20) begin step; t++; end
    chk("hold_rise", 32'(HOLD), 32'd1);
    step; step;
    HLDA = 1'b1;
  endtask

  task automatic wait_ale;
    int t = 0;
    while (!ALE && t < 20) begin step; t++; end
    chk("ale", 32'(ALE), 32'd1);
  endtask

  // One bus cycle for channel ch, from T1 through the done pulse in T4
  task automatic run_xfer(input int ch, input bit wr, input logic [19:0] a, input bit iom,
                          input int stall, input bit drop, input bit hdrop);
    int n = 0;
    int t = 0;
    bit other = 0;
    bit moved = 0;
    logic [NR-1:0] oh;
    oh = NR'(1) << ch;
    wait_ale;
    chk("t1_addr", 32'(Address), 32'(a));
    chk("t1_iom", 32'(IOM), 32'(iom));
    chk("t1_gnt", 32'(gnt), 32'(oh));
    do begin
      step; t++;
      if (hdrop && t == 1) HLDA = 1'b0;
      if (!(wr ? WR : RD)) n++;
      if (!(wr ? RD : WR)) other = 1;
      if (Address !== a) moved = 1;
      rdy = (n >= 2 + WS + stall);
    end while (done == '0 && t < 40);
    chk("done", 32'(done), 32'(oh));
    chk("strobe_cycles", 32'(n), 32'(2 + WS + stall));
    chk("other_strobe", 32'(other), 32'd0);
    chk("addr_stable", 32'(moved), 32'd0);
    chk("t4_strobes", {30'd0, RD, WR}, 32'd3);
    if (drop) req[ch] = 1'b0;
  endtask

  task automatic release_chk;
    step;
    chk("rel_hold", 32'(HOLD), 32'd0);
    chk("rel_gnt", 32'(gnt), 32'd0);
    chk("done_1cyc", 32'(done), 32'd0);
    HLDA = 1'b0;
    step;
    chk("idle_hold", 32'(HOLD), 32'd0);
  endtask

  initial begin
    int ch;
    logic [19:0] a0, a1;
    a0 = 20'h81234;
    a1 = 20'h00F20;
    // Power-on reset
    step; step;
    chk("rst_hold", 32'(HOLD), 32'd0);
    chk("rst_strobes", {30'd0, RD, WR}, 32'd3);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_addr", 32'(Address), 32'd0);
    rst = 1'b1;

    // Reset asserted mid-T3 with all requests active
    req_addr = {a1, a0};
    req = 2'b11; rdy = 1'b0;
    start_hold;
    wait_ale;
    step; step; step; step;
    chk("pre_rst_rd", 32'(RD), 32'd0);
    rst = 1'b0;
    step;
    chk("mid_rst_hold", 32'(HOLD), 32'd0);
    chk("mid_rst_strobes", {30'd0, RD, WR}, 32'd3);
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_ale", 32'(ALE), 32'd0);
    step;
    chk("mid_rst_hold2", 32'(HOLD), 32'd0);
    rst = 1'b1; req = '0; HLDA = 1'b0; rdy = 1'b1;
    step;
    chk("post_rst_hold", 32'(HOLD), 32'd0);

    // Single read on ch0
    req = 2'b01;
    start_hold;
    run_xfer(0, 0, a0, 0, 0, 1, 0);
    release_chk;

    // Read with three rdy-low T3 cycles
    req_addr[19:0] = 20'h25A5A;
    req = 2'b01;
    start_hold;
    run_xfer(0, 0, 20'h25A5A, 0, 3, 1, 0);
    release_chk;

    // IO write on ch1
    req_wr = 2'b10; req_iom = 2'b10;
    req = 2'b10;
    start_hold;
    run_xfer(1, 1, a1, 1, 0, 1, 0);
    release_chk;

    // Fairness with both requesters held; reset first to restore the pointer
    rst = 1'b0; step; step; rst = 1'b1;
    req_wr = '0; req_iom = '0; req_addr = {a1, a0};
    req = 2'b11;
    start_hold;
    for (int k = 0; k < 16; k++) begin
`ifdef ARB_FIXED_PRIO_EN
      ch = 0;
`else
      ch = (k / MB) % 2;
`endif
      run_xfer(ch, 0, (ch == 0) ? a0 : a1, 0, 0, k == 15, 0);
      chk("burst_hold", 32'(HOLD), 32'd1);
      if (k == 15) req = '0;
    end
    release_chk;

    // HLDA lost during T2: cycle completes, then release despite pending req
    req = 2'b01;
    start_hold;
    run_xfer(0, 0, a0, 0, 0, 0, 1);
    step;
    chk("hlda_rel_hold", 32'(HOLD), 32'd0);
    chk("hlda_rel_gnt", 32'(gnt), 32'd0);
    step;
    chk("hlda_idle_hold", 32'(HOLD), 32'd0);
    step;
    chk("hlda_rehold", 32'(HOLD), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
